keypad_entry: RTL and testbench

Scanned 4x4 matrix keypad reader that builds a two-digit BCD value from key presses. It is the input-side counterpart of the multiplexed two-digit 7-segment display path. It time-multiplexes the keypad columns the same way the display multiplexes its digit commons, then debounces and decodes the keys. Its tens/ones outputs feed the display and the tone/timer logic directly.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_debounce.sv | 108 ++++++++++
 rtl/keypad_entry.sv | 124 ++++++++++++
 tb/tb_keypad_entry.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the scanned 4x4 keypad reader.
// Key codes, debounce state encoding and the row/column to code map.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } db_state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a key after DB_COUNT matching frames and
// re-arms only after DB_COUNT consecutive empty frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no key held; waiting for any key in a frame
//   DEBOUNCE | candidate seen, counting consecutive frames of same key
//   HELD     | key accepted; counting empty frames before re-arming
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DB_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_present,
    input  logic [3:0] key_code,
    output logic       accept,
    output logic [3:0] code
);

    localparam int CW = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0] DB_TC = CW'(DB_COUNT);

    db_state_t     state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rcnt, rcnt_n;
    logic          accept_n;
    logic [3:0]    code_n;
    logic [CW-1:0] cnt_inc, rcnt_inc;

    assign cnt_inc  = cnt + 1'b1;
    assign rcnt_inc = rcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cand   <= '0;
            cnt    <= '0;
            rcnt   <= '0;
            accept <= 1'b0;
            code   <= '0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            rcnt   <= rcnt_n;
            accept <= accept_n;
            code   <= code_n;
        end
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        rcnt_n   = rcnt;
        accept_n = 1'b0;
        code_n   = code;
        if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    if (key_present) begin
                        cand_n = key_code;
                        cnt_n  = CW'(1);
                        if (DB_COUNT == 1) begin
                            accept_n = 1'b1;
                            code_n   = key_code;
                            rcnt_n   = '0;
                            state_n  = ST_HELD;
                        end else begin
                            state_n  = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!key_present) begin
                        state_n = ST_IDLE;
                    end else if (key_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB_TC) begin
                            accept_n = 1'b1;
                            code_n   = cand;
                            rcnt_n   = '0;
                            state_n  = ST_HELD;
                        end
                    end else begin
                        cand_n = key_code;
                        cnt_n  = CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!key_present) begin
                        rcnt_n = rcnt_inc;
                        if (rcnt_inc >= DB_TC)
                            state_n = ST_IDLE;
                    end else begin
                        rcnt_n = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with row synchronizer, frame priority pick, debounce and
// a two-digit BCD entry register (digits shift in, '*' clears, '#' commits).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4000,
    parameter int DB_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       entry_valid
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_TC = DW'(SCAN_DIV - 1);

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic          tick;
    logic          cur_hit;
    logic [1:0]    cur_row;
    logic [3:0]    cur_code;
    logic          found;
    logic [3:0]    fcode;
    logic          frame_tick;
    logic          frame_present;
    logic [3:0]    frame_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    assign tick = (div == DIV_TC);
    assign col  = ~(4'b0001 << idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        cur_row = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (!row_s2[r])
                cur_row = 2'(r);
    end

    assign cur_hit  = ~&row_s2;
    assign cur_code = key_lookup(cur_row, idx);

    // Columns are visited in ascending order, so the first hit in a frame is
    // the lowest column; later hits are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            found <= 1'b0;
            fcode <= '0;
        end else if (tick) begin
            if (idx == 2'd3) begin
                found <= 1'b0;
            end else if (!found && cur_hit) begin
                found <= 1'b1;
                fcode <= cur_code;
            end
        end
    end

    assign frame_tick    = tick && (idx == 2'd3);
    assign frame_present = found | cur_hit;
    assign frame_code    = found ? fcode : cur_code;

    keypad_debounce #(
        .DB_COUNT (DB_COUNT)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .key_present (frame_present),
        .key_code    (frame_code),
        .accept      (key_valid),
        .code        (key_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tens        <= '0;
            ones        <= '0;
            entry_valid <= 1'b0;
        end else begin
            entry_valid <= 1'b0;
            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    tens <= ones;
                    ones <= key_code;
                end else if (key_code == KEY_STAR) begin
                    tens <= '0;
                    ones <= '0;
                end else if (key_code == KEY_HASH) begin
                    entry_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_DIV=4, DB_COUNT=2 (16-cycle frames)
// and a reactive keypad model driving row from col and a pressed-key mask.
module tb_keypad_entry;

    localparam int K1 = 0, K3 = 2, K4 = 4, K5 = 5, K2 = 1;
    localparam int K7 = 8, K9 = 10, KSTAR = 12, KHASH = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] tens, ones;
    logic       entry_valid;

    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kv_cnt = 0, ev_cnt = 0;
    int kv_cyc = 0, ev_cyc = 0;
    logic [3:0] kv_last = '0;
    logic [3:0] ev_tens = '0, ev_ones = '0;

    keypad_entry #(
        .SCAN_DIV (4),
        .DB_COUNT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .tens        (tens),
        .ones        (ones),
        .entry_valid (entry_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt  = kv_cnt + 1;
            kv_last = key_code;
            kv_cyc  = cyc;
        end
        if (entry_valid) begin
            ev_cnt  = ev_cnt + 1;
            ev_cyc  = cyc;
            ev_tens = tens;
            ev_ones = ones;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        cycles(16 * n);
    endtask

    task automatic do_keys(input logic [15:0] mask, input int hold, input int rel);
        keys = mask;
        frames(hold);
        keys = '0;
        frames(rel);
    endtask

    initial begin
        // reset and column rotation
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        check("rst_col", col, 4'b1110);
        check("rst_kv", key_valid, 1'b0);
        check("rst_ev", entry_valid, 1'b0);
        check("rst_tens", tens, 4'd0);
        check("rst_ones", ones, 4'd0);
        check("rst_code", key_code, 4'd0);
        cycles(4);
        check("col_1", col, 4'b1101);
        cycles(4);
        check("col_2", col, 4'b1011);
        cycles(4);
        check("col_3", col, 4'b0111);
        cycles(4);
        check("col_wrap", col, 4'b1110);

        // single press of 5: accepted at the end of the second frame
        keys = 16'b1 << K5;
        cycles(31);
        check("k5_early", key_valid, 1'b0);
        cycles(1);
        check("k5_kv", key_valid, 1'b1);
        check("k5_code", key_code, 4'h5);
        check("k5_ones_lag", ones, 4'h0);
        cycles(1);
        check("k5_kv_pulse", key_valid, 1'b0);
        check("k5_ones", ones, 4'h5);
        check("k5_tens", tens, 4'h0);
        cycles(15);
        frames(2);
        keys = '0;
        frames(2);
        check("k5_count", kv_cnt, 1);

        // entry sequence 4, 2, #, then *
        do_keys(16'b1 << K4, 3, 3);
        do_keys(16'b1 << K2, 3, 3);
        check("ent_tens", tens, 4'h4);
        check("ent_ones", ones, 4'h2);
        do_keys(16'b1 << KHASH, 3, 3);
        check("hash_code", kv_last, 4'hF);
        check("hash_ev_cnt", ev_cnt, 1);
        check("hash_ev_lag", ev_cyc - kv_cyc, 1);
        check("hash_ev_tens", ev_tens, 4'h4);
        check("hash_ev_ones", ev_ones, 4'h2);
        check("hash_tens", tens, 4'h4);
        check("hash_ones", ones, 4'h2);
        do_keys(16'b1 << KSTAR, 3, 3);
        check("star_code", kv_last, 4'hE);
        check("star_tens", tens, 4'h0);
        check("star_ones", ones, 4'h0);
        check("seq_count", kv_cnt, 5);

        // bounce on 7 is rejected
        do_keys(16'b1 << K7, 1, 1);
        do_keys(16'b1 << K7, 1, 2);
        check("bounce_count", kv_cnt, 5);

        // hold 9, short release ignored, full release re-arms
        keys = 16'b1 << K9;
        frames(10);
        check("hold_count", kv_cnt, 6);
        keys = '0;
        frames(1);
        keys = 16'b1 << K9;
        frames(2);
        check("repress_none", kv_cnt, 6);
        keys = '0;
        frames(2);
        do_keys(16'b1 << K9, 2, 2);
        check("repress_count", kv_cnt, 7);
        check("repress_code", kv_last, 4'h9);
        check("nine_tens", tens, 4'h9);
        check("nine_ones", ones, 4'h9);

        // simultaneous keys: lowest column, then lowest row
        do_keys((16'b1 << K1) | (16'b1 << K9), 3, 2);
        check("multi_1_9", kv_last, 4'h1);
        do_keys((16'b1 << K3) | (16'b1 << K4), 3, 2);
        check("multi_3_4", kv_last, 4'h4);
        check("multi_count", kv_cnt, 9);
        check("multi_ones", ones, 4'h4);

        // reset after one debounce frame of 3 discards the candidate
        keys = 16'b1 << K3;
        frames(1);
        rst = 1'b1;
        cycles(2);
        check("mrst_col", col, 4'b1110);
        check("mrst_code", key_code, 4'h0);
        check("mrst_ones", ones, 4'h0);
        rst = 1'b0;
        cycles(31);
        check("mrst_early", kv_cnt, 9);
        cycles(1);
        check("mrst_kv", key_valid, 1'b1);
        check("mrst_code3", key_code, 4'h3);
        cycles(1);
        check("mrst_ones3", ones, 4'h3);
        check("mrst_tens", tens, 4'h0);
        keys = '0;
        frames(3);
        check("final_count", kv_cnt, 10);
        check("final_ev", ev_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
